// File: rtl/counter_sequencer.sv
// Loadable up/down count sequencer with terminal match, pause/hold,
// abort and optional auto-reload; done pulses once per terminal match.
module counter_sequencer #(
    parameter int bits = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic            pause,
    input  logic            dir,
    input  logic            auto_reload,
    input  logic [bits-1:0] load_val,
    input  logic [bits-1:0] term_val,
    output logic [bits-1:0] count,
    output logic            busy,
    output logic            done,
    output logic [7:0]      reload_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [bits-1:0] ONE = 1;

    state_t          state_q, state_d;
    logic [bits-1:0] count_q, count_d;
    logic [bits-1:0] load_q, load_d;
    logic [bits-1:0] term_q, term_d;
    logic            dir_q, dir_d;
    logic            reload_q, reload_d;
    logic [7:0]      rcnt_q, rcnt_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            load_q   <= '0;
            term_q   <= '0;
            dir_q    <= 1'b0;
            reload_q <= 1'b0;
            rcnt_q   <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            load_q   <= load_d;
            term_q   <= term_d;
            dir_q    <= dir_d;
            reload_q <= reload_d;
            rcnt_q   <= rcnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        load_d   = load_q;
        term_d   = term_q;
        dir_d    = dir_q;
        reload_d = reload_q;
        rcnt_d   = rcnt_q;
        done_d   = 1'b0;
        // stop overrides everything and leaves count/reload_cnt untouched
        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d  = RUN;
                        count_d  = load_val;
                        load_d   = load_val;
                        term_d   = term_val;
                        dir_d    = dir;
                        reload_d = auto_reload;
                        rcnt_d   = '0;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = HOLD;
                    end else if (count_q == term_q) begin
                        done_d = 1'b1;
                        if (reload_q) begin
                            count_d = load_q;
                            if (rcnt_q != 8'hFF) rcnt_d = rcnt_q + 8'd1;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        count_d = dir_q ? count_q + ONE : count_q - ONE;
                    end
                end
                HOLD: begin
                    if (!pause) state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == RUN) || (state_d == HOLD);
    end

    assign count      = count_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign reload_cnt = rcnt_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: vector table plus model-driven scoreboard.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, pause = 1'b0;
    logic       dir = 1'b0, auto_reload = 1'b0;
    logic [3:0] load_val = '0, term_val = '0;
    logic [3:0] count;
    logic       busy, done;
    logic [7:0] reload_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    counter_sequencer #(.bits(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .dir(dir), .auto_reload(auto_reload), .load_val(load_val),
        .term_val(term_val), .count(count), .busy(busy), .done(done),
        .reload_cnt(reload_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cnt;
        logic       busy;
        logic       done;
        logic [7:0] rc;
    } exp_t;

    typedef struct {
        logic       start, stop, pause, dir, ar;
        logic [3:0] lv, tv;
        logic [3:0] ecnt;
        logic       ebusy, edone;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[7];

    // reference model: 0 idle, 1 run, 2 hold, 3 done
    int m_st, m_cnt, m_ld, m_tm, m_rc;
    bit m_dir, m_ar, m_done;

    function automatic void model_reset();
        m_st = 0; m_cnt = 0; m_ld = 0; m_tm = 0; m_rc = 0;
        m_dir = 0; m_ar = 0; m_done = 0;
    endfunction

    function automatic void model_step(bit s, bit sp, bit pa, bit d, bit ar,
                                       int lv, int tv);
        m_done = 0;
        if (sp) m_st = 0;
        else if (m_st == 0 || m_st == 3) begin
            if (s) begin
                m_st = 1; m_cnt = lv; m_ld = lv; m_tm = tv;
                m_dir = d; m_ar = ar; m_rc = 0;
            end
        end else if (m_st == 2) begin
            if (!pa) m_st = 1;
        end else begin
            if (pa) m_st = 2;
            else if (m_cnt == m_tm) begin
                m_done = 1;
                if (m_ar) begin
                    m_cnt = m_ld;
                    if (m_rc < 255) m_rc++;
                end else m_st = 3;
            end else m_cnt = m_dir ? (m_cnt + 1) % 16 : (m_cnt + 15) % 16;
        end
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        e.cnt  = 4'(m_cnt);
        e.busy = (m_st == 1 || m_st == 2);
        e.done = m_done;
        e.rc   = 8'(m_rc);
        return e;
    endfunction

    task automatic check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        n_tests += 4;
        if (count !== e.cnt) begin
            n_fail++;
            $display("FAIL %s count: got %0d want %0d", tag, count, e.cnt);
        end
        if (busy !== e.busy) begin
            n_fail++;
            $display("FAIL %s busy: got %b want %b", tag, busy, e.busy);
        end
        if (done !== e.done) begin
            n_fail++;
            $display("FAIL %s done: got %b want %b", tag, done, e.done);
        end
        if (reload_cnt !== e.rc) begin
            n_fail++;
            $display("FAIL %s reload_cnt: got %0d want %0d", tag, reload_cnt, e.rc);
        end
    endtask

    task automatic step(input string tag, input bit s, input bit sp,
                        input bit pa, input bit d, input bit ar,
                        input logic [3:0] lv, input logic [3:0] tv);
        @(negedge clk);
        start = s; stop = sp; pause = pa; dir = d; auto_reload = ar;
        load_val = lv; term_val = tv;
        model_step(s, sp, pa, d, ar, int'(lv), int'(tv));
        sb.push_back(model_exp());
        @(posedge clk);
        #1;
        check(tag);
    endtask

    task automatic idle_step(input string tag, input bit pa);
        step(tag, 1'b0, 1'b0, pa, 1'($urandom), 1'($urandom),
             4'($urandom), 4'($urandom));
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        sb.push_back(model_exp());
        #1;
        check(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        exp_t e;
        vec_t v;
        // up count 2..5 one-shot; load/term/dir scrambled after capture
        tbl[0] = '{1,0,0,1,0, 4'd2, 4'd5,  4'd2, 1, 0};
        tbl[1] = '{0,0,0,0,1, 4'd9, 4'd1,  4'd3, 1, 0};
        tbl[2] = '{1,0,0,0,1, 4'd7, 4'd3,  4'd4, 1, 0};
        tbl[3] = '{0,0,0,0,0, 4'd0, 4'd0,  4'd5, 1, 0};
        tbl[4] = '{0,0,0,1,0, 4'd2, 4'd5,  4'd5, 0, 1};
        tbl[5] = '{0,0,0,1,0, 4'd2, 4'd5,  4'd5, 0, 0};
        tbl[6] = '{0,0,0,1,0, 4'd2, 4'd5,  4'd5, 0, 0};

        model_reset();
        #1;
        sb.push_back(model_exp());
        check("reset_state");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            v = tbl[i];
            @(negedge clk);
            start = v.start; stop = v.stop; pause = v.pause;
            dir = v.dir; auto_reload = v.ar;
            load_val = v.lv; term_val = v.tv;
            model_step(v.start, v.stop, v.pause, v.dir, v.ar,
                       int'(v.lv), int'(v.tv));
            e.cnt = v.ecnt; e.busy = v.ebusy; e.done = v.edone; e.rc = 8'd0;
            sb.push_back(e);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d", i));
        end

        step("down_start", 1, 0, 0, 0, 0, 4'd1, 4'd14);
        for (int i = 0; i < 6; i++) idle_step("down_wrap", 0);

        step("ar_start", 1, 0, 0, 1, 1, 4'd3, 4'd5);
        for (int i = 0; i < 12; i++) idle_step("ar_run", 0);
        for (int i = 0; i < 780; i++) idle_step("ar_long", 0);
        n_tests++;
        if (reload_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL ar_sat: got %0d want 255", reload_cnt);
        end
        step("ar_stop", 0, 1, 0, 0, 0, 4'd0, 4'd0);

        step("pz_start", 1, 0, 0, 1, 0, 4'd0, 4'd9);
        for (int i = 0; i < 4; i++) idle_step("pz_run", 0);
        for (int i = 0; i < 4; i++) idle_step("pz_hold", 1);
        for (int i = 0; i < 7; i++) idle_step("pz_resume", 0);

        step("pm_start", 1, 0, 0, 1, 0, 4'd5, 4'd6);
        idle_step("pm_step", 0);
        idle_step("pm_pause_on_match", 1);
        idle_step("pm_hold", 1);
        idle_step("pm_release", 0);
        idle_step("pm_match", 0);
        idle_step("pm_after", 0);

        step("ss_same", 1, 1, 0, 1, 0, 4'd8, 4'd2);
        idle_step("ss_idle", 0);
        step("st_start", 1, 0, 0, 1, 0, 4'd4, 4'd12);
        idle_step("st_run", 0);
        idle_step("st_run", 0);
        step("st_ignored", 1, 0, 0, 0, 1, 4'd1, 4'd1);
        step("st_stop", 0, 1, 0, 1, 0, 4'd0, 4'd0);
        idle_step("st_idle", 0);

        step("rs_start", 1, 0, 0, 1, 1, 4'd2, 4'd10);
        idle_step("rs_run", 0);
        idle_step("rs_run", 0);
        async_reset("rs_async");
        idle_step("rs_wait", 0);
        step("eq_start", 1, 0, 0, 1, 0, 4'd9, 4'd9);
        idle_step("eq_match", 0);
        idle_step("eq_after", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
